encoder_position_counter: RTL and testbench
===========================================

Name: encoder_position_counter

Overview:
- Downstream consumer of the quadrature direction decoder's one-cycle Clockwise / counterClockwise pulses.
- Maintains a bounded position value (wrap or saturate) with speed-dependent acceleration.
- Supports synchronous load and publishes change/limit flags for display and menu logic (7-seg value, LED bar).

Parameters:
- WIDTH, 8, position width in bits.
- MIN_VAL, 0, lowest legal position.
- MAX_VAL, 99, highest legal position; MIN_VAL < MAX_VAL <= 2^WIDTH-1.
- WRAP, 1, 1 = wrap at limits, 0 = saturate.
- ACCEL_WINDOW, 5_000_000, max cycle gap between same-direction pulses that still counts as "fast" (50 ms at 100 MHz).
- ACCEL_STEP, 5, step size in fast mode; 1 <= ACCEL_STEP <= MAX_VAL-MIN_VAL.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- cw_pulse  in  1  one-cycle clockwise detent pulse.
- ccw_pulse  in  1  one-cycle counter-clockwise detent pulse.
- load  in  1  load load_value this cycle.
- load_value  in  WIDTH  value to load.
- position  out  WIDTH  current position, registered.
- changed  out  1  one-cycle strobe when position took a new value.
- at_min  out  1  position == MIN_VAL.
- at_max  out  1  position == MAX_VAL.
- dir_last  out  1  direction of last accepted pulse (1 = cw).
- fast  out  1  accel FSM is in FAST.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - position = MIN_VAL; changed = 0; at_min = 1; at_max = 0; dir_last = 1; fast = 0.
  - Gap counter = ACCEL_WINDOW (saturated); FSM = SLOW.
- Accepted pulse: exactly one of cw_pulse/ccw_pulse high. Both high -> ignored entirely: no position change, gap counter keeps counting, FSM unchanged.
- Priority: reset > load > pulse. A pulse in the same cycle as load is dropped.
- Latency: position, changed and flags update on the clock edge that samples the pulse or load (1 cycle).
- Gap counter:
  - Cleared to 0 on every accepted pulse.
  - Otherwise increments and saturates at ACCEL_WINDOW.
- Accel FSM (SLOW, FAST), evaluated on each accepted pulse:
  - Goes to FAST when gap < ACCEL_WINDOW and direction == dir_last.
  - Otherwise goes to SLOW.
  - Gap reaching ACCEL_WINDOW with no pulse forces SLOW.
  - Load forces SLOW and saturates the gap counter.
- Step size: step = ACCEL_STEP if the next state is FAST, else 1. The transition and the step apply on the same edge.
- Arithmetic: computed in WIDTH+2 bits, never truncated before the limit check.
  - cw: n = position + step.
  - ccw: n = position - step.
- Wrap mode (WRAP=1), span = MAX_VAL-MIN_VAL+1:
  - n > MAX_VAL -> n - span.
  - n < MIN_VAL -> n + span.
  - Examples: MAX 99, pos 97, step 5 -> 2; pos 0, ccw step 1 -> 99.
- Saturate mode (WRAP=0): clamp to [MIN_VAL, MAX_VAL].
- Load: load_value is clamped into [MIN_VAL, MAX_VAL] before being stored.
- changed: high for one cycle only if the new position != old position. Saturated pulses and loads of the current value give changed = 0.
- dir_last: updated on every accepted pulse, including saturated ones.
- at_min / at_max: registered, always consistent with position in the same cycle.
- Reset mid-burst: all state returns to reset values; the next pulse steps by 1.

Decomposition:
- Package encoder_pkg:
  - Accel state enum {SLOW, FAST}.
  - DIR_CW = 1'b1, DIR_CCW = 1'b0.
  - Localparam helper for span.
- One sub-module, accel_timer: gap counter plus SLOW/FAST FSM.
  - Inputs: clk, reset, pulse_valid, pulse_dir, clear.
  - Outputs: fast_next, dir_last.
- Top module: limit/wrap arithmetic, load clamp, flags.

Test Plan:
All scenarios use ACCEL_WINDOW=16, ACCEL_STEP=5, MIN 0, MAX 99, unless stated.
- Reset, then 3 cw pulses spaced 40 cycles apart -> position 1, 2, 3; changed pulses each once; fast stays 0.
- 4 cw pulses spaced 4 cycles apart from pos 0 -> 1, 6, 11, 16; fast rises on 2nd pulse. Then idle 20 cycles -> fast = 0; next cw pulse -> 17.
- WRAP=1: load 97, then fast cw pair -> 98 then 3 (98+5-100). From 0, slow ccw -> 99 with at_max = 1.
- WRAP=0: load 150 -> position 99 (clamped), at_max = 1. Next cw pulse -> position stays 99, changed = 0, dir_last = 1.
- cw and ccw high in the same cycle -> position and FSM unchanged, changed = 0. Load 42 with cw in the same cycle -> position 42, fast = 0.
- Fast cw burst reaches fast = 1, then a ccw pulse 3 cycles later -> step 1 (direction reversal), fast = 0. Reset asserted mid-burst -> position 0, at_min = 1.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types and helpers for the encoder position counter.
//   accel_state_t : acceleration FSM state (SLOW / FAST)
//   DIR_CW/DIR_CCW: encoding of pulse direction (1 = clockwise)
//   calc_span     : number of legal positions in [min_val, max_val]
package encoder_pkg;

  typedef enum logic [0:0] {
    SLOW = 1'b0,
    FAST = 1'b1
  } accel_state_t;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  function automatic int unsigned calc_span(input int unsigned min_val,
                                            input int unsigned max_val);
    return max_val - min_val + 1;
  endfunction

endpackage

// File: rtl/encoder_position_counter_accel_timer.sv
// Acceleration timer: gap counter between accepted pulses plus SLOW/FAST FSM.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   pulse_valid  : an accepted (single-direction, non-load) detent pulse
//   pulse_dir    : direction of that pulse (1 = cw)
//   clear        : load in progress; forces SLOW and saturates the gap
//   fast_next    : FSM state that takes effect on this edge (sizes the step)
//   fast         : FSM currently in FAST
//   dir_last     : direction of the last accepted pulse
module accel_timer
  import encoder_pkg::*;
#(
  parameter int unsigned ACCEL_WINDOW = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_valid,
  input  logic pulse_dir,
  input  logic clear,
  output logic fast_next,
  output logic fast,
  output logic dir_last
);

  localparam int unsigned    GAP_W   = $clog2(ACCEL_WINDOW + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(ACCEL_WINDOW);

  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] gap_next;
  accel_state_t     state;
  accel_state_t     state_next;

  always_comb begin
    gap_next   = gap;
    state_next = state;
    if (clear) begin
      gap_next   = GAP_MAX;
      state_next = SLOW;
    end else if (pulse_valid) begin
      gap_next   = '0;
      state_next = ((gap < GAP_MAX) && (pulse_dir == dir_last)) ? FAST : SLOW;
    end else begin
      if (gap != GAP_MAX) begin
        gap_next = gap + 1'b1;
      end
      // Idle long enough to leave the fast window: drop back on the edge the
      // counter saturates.
      if (gap_next == GAP_MAX) begin
        state_next = SLOW;
      end
    end
  end

  assign fast_next = (state_next == FAST);
  assign fast      = (state == FAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      gap      <= GAP_MAX;
      state    <= SLOW;
      dir_last <= DIR_CW;
    end else begin
      gap   <= gap_next;
      state <= state_next;
      if (pulse_valid && !clear) begin
        dir_last <= pulse_dir;
      end
    end
  end

endmodule

// File: rtl/encoder_position_counter.sv
// Bounded position counter driven by quadrature detent pulses.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   cw_pulse         : one-cycle clockwise detent pulse
//   ccw_pulse        : one-cycle counter-clockwise detent pulse
//   load, load_value : synchronous load (value clamped into range)
//   position         : registered position in [MIN_VAL, MAX_VAL]
//   changed          : one-cycle strobe when position took a new value
//   at_min, at_max   : position sits on a limit
//   dir_last         : direction of last accepted pulse (1 = cw)
//   fast             : acceleration FSM is in FAST
module encoder_position_counter
  import encoder_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned MIN_VAL      = 0,
  parameter int unsigned MAX_VAL      = 99,
  parameter int unsigned WRAP         = 1,
  parameter int unsigned ACCEL_WINDOW = 5_000_000,
  parameter int unsigned ACCEL_STEP   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cw_pulse,
  input  logic             ccw_pulse,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] position,
  output logic             changed,
  output logic             at_min,
  output logic             at_max,
  output logic             dir_last,
  output logic             fast
);

  localparam int unsigned SPAN = calc_span(MIN_VAL, MAX_VAL);

  localparam logic [WIDTH-1:0]        MIN_W  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0]        MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0]        STEP_W = WIDTH'(ACCEL_STEP);
  localparam logic signed [WIDTH+1:0] MIN_X  = (WIDTH+2)'(MIN_VAL);
  localparam logic signed [WIDTH+1:0] MAX_X  = (WIDTH+2)'(MAX_VAL);
  localparam logic signed [WIDTH+1:0] SPAN_X = (WIDTH+2)'(SPAN);

  logic                    pulse_accepted;
  logic                    pulse_valid;
  logic                    pulse_dir;
  logic                    fast_next;
  logic [WIDTH-1:0]        step;
  logic signed [WIDTH+1:0] pos_x;
  logic signed [WIDTH+1:0] step_x;
  logic signed [WIDTH+1:0] sum_x;
  logic signed [WIDTH+1:0] lim_x;
  logic signed [WIDTH+1:0] ld_x;
  logic signed [WIDTH+1:0] ld_lim_x;
  logic [WIDTH-1:0]        next_pos;

  // Both directions at once is treated as noise; load drops any pulse.
  assign pulse_accepted = cw_pulse ^ ccw_pulse;
  assign pulse_valid    = pulse_accepted && !load;
  assign pulse_dir      = cw_pulse ? DIR_CW : DIR_CCW;

  accel_timer #(
    .ACCEL_WINDOW (ACCEL_WINDOW)
  ) u_accel_timer (
    .clk         (clk),
    .reset       (reset),
    .pulse_valid (pulse_valid),
    .pulse_dir   (pulse_dir),
    .clear       (load),
    .fast_next   (fast_next),
    .fast        (fast),
    .dir_last    (dir_last)
  );

  // Two guard bits keep both the overflow above MAX and the underflow below
  // zero representable, so the limit check sees the true result.
  always_comb begin
    step   = fast_next ? STEP_W : WIDTH'(1);
    pos_x  = signed'({2'b00, position});
    step_x = signed'({2'b00, step});
    sum_x  = (pulse_dir == DIR_CW) ? (pos_x + step_x) : (pos_x - step_x);

    lim_x = sum_x;
    if (WRAP != 0) begin
      if (sum_x > MAX_X) begin
        lim_x = sum_x - SPAN_X;
      end else if (sum_x < MIN_X) begin
        lim_x = sum_x + SPAN_X;
      end
    end else begin
      if (sum_x > MAX_X) begin
        lim_x = MAX_X;
      end else if (sum_x < MIN_X) begin
        lim_x = MIN_X;
      end
    end

    ld_x     = signed'({2'b00, load_value});
    ld_lim_x = ld_x;
    if (ld_x > MAX_X) begin
      ld_lim_x = MAX_X;
    end else if (ld_x < MIN_X) begin
      ld_lim_x = MIN_X;
    end

    next_pos = position;
    if (load) begin
      next_pos = ld_lim_x[WIDTH-1:0];
    end else if (pulse_valid) begin
      next_pos = lim_x[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      position <= MIN_W;
      changed  <= 1'b0;
      at_min   <= 1'b1;
      at_max   <= 1'b0;
    end else begin
      position <= next_pos;
      changed  <= (next_pos != position);
      at_min   <= (next_pos == MIN_W);
      at_max   <= (next_pos == MAX_W);
    end
  end

endmodule

// File: tb/tb_encoder_position_counter.sv
module tb_encoder_position_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cw_pulse;
  logic       ccw_pulse;
  logic       load;
  logic [7:0] load_value;

  logic [7:0] w_pos, s_pos;
  logic       w_chg, s_chg, w_min, s_min, w_max, s_max, w_dir, s_dir, w_fast, s_fast;

  bit         sel_sat;
  logic [7:0] o_pos;
  logic       o_chg, o_min, o_max, o_dir, o_fast;

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;

  always #5 clk = ~clk;

  encoder_position_counter #(
    .WIDTH(8), .MIN_VAL(0), .MAX_VAL(99), .WRAP(1), .ACCEL_WINDOW(16), .ACCEL_STEP(5)
  ) dut_wrap (
    .clk(clk), .reset(reset), .cw_pulse(cw_pulse), .ccw_pulse(ccw_pulse),
    .load(load), .load_value(load_value), .position(w_pos), .changed(w_chg),
    .at_min(w_min), .at_max(w_max), .dir_last(w_dir), .fast(w_fast)
  );

  encoder_position_counter #(
    .WIDTH(8), .MIN_VAL(0), .MAX_VAL(99), .WRAP(0), .ACCEL_WINDOW(16), .ACCEL_STEP(5)
  ) dut_sat (
    .clk(clk), .reset(reset), .cw_pulse(cw_pulse), .ccw_pulse(ccw_pulse),
    .load(load), .load_value(load_value), .position(s_pos), .changed(s_chg),
    .at_min(s_min), .at_max(s_max), .dir_last(s_dir), .fast(s_fast)
  );

  assign o_pos  = sel_sat ? s_pos  : w_pos;
  assign o_chg  = sel_sat ? s_chg  : w_chg;
  assign o_min  = sel_sat ? s_min  : w_min;
  assign o_max  = sel_sat ? s_max  : w_max;
  assign o_dir  = sel_sat ? s_dir  : w_dir;
  assign o_fast = sel_sat ? s_fast : w_fast;

  typedef struct {
    int unsigned idle;
    logic        cw;
    logic        ccw;
    logic        ld;
    logic [7:0]  lv;
    logic [7:0]  pos;
    logic        chg;
    logic        amin;
    logic        amax;
    logic        dir;
    logic        fst;
  } vec_t;

  function automatic vec_t mk(input int unsigned idle, input logic cw, input logic ccw,
                              input logic ld, input logic [7:0] lv, input logic [7:0] pos,
                              input logic chg, input logic amin, input logic amax,
                              input logic dir, input logic fst);
    vec_t v;
    v.idle = idle; v.cw = cw; v.ccw = ccw; v.ld = ld; v.lv = lv;
    v.pos = pos; v.chg = chg; v.amin = amin; v.amax = amax; v.dir = dir; v.fst = fst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] pos, input logic chg,
                         input logic amin, input logic amax, input logic dir, input logic fst);
    chk({tag, ".position"}, 32'(o_pos), 32'(pos));
    chk({tag, ".changed"},  32'(o_chg), 32'(chg));
    chk({tag, ".at_min"},   32'(o_min), 32'(amin));
    chk({tag, ".at_max"},   32'(o_max), 32'(amax));
    chk({tag, ".dir_last"}, 32'(o_dir), 32'(dir));
    chk({tag, ".fast"},     32'(o_fast), 32'(fst));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    repeat (v.idle) @(posedge clk);
    @(negedge clk);
    cw_pulse   = v.cw;
    ccw_pulse  = v.ccw;
    load       = v.ld;
    load_value = v.lv;
    @(posedge clk);
    #1;
    cw_pulse  = 1'b0;
    ccw_pulse = 1'b0;
    load      = 1'b0;
    chk_all(tag, v.pos, v.chg, v.amin, v.amax, v.dir, v.fst);
  endtask

  // One reset cycle; cw held high alongside to show reset wins.
  task automatic do_reset(input logic with_cw);
    @(negedge clk);
    reset    = 1'b1;
    cw_pulse = with_cw;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    cw_pulse = 1'b0;
  endtask

  vec_t va[33];
  vec_t vb[10];

  initial begin
    reset = 1'b1; cw_pulse = 1'b0; ccw_pulse = 1'b0; load = 1'b0; load_value = '0;
    sel_sat = 1'b0;

    //          idle cw ccw ld  lv   pos chg min max dir fast
    va[0]  = mk(0,  1, 0, 0, 0,   1,  1, 0, 0, 1, 0);
    va[1]  = mk(39, 1, 0, 0, 0,   2,  1, 0, 0, 1, 0);
    va[2]  = mk(39, 1, 0, 0, 0,   3,  1, 0, 0, 1, 0);
    va[3]  = mk(0,  0, 0, 0, 0,   3,  0, 0, 0, 1, 0);
    va[4]  = mk(0,  0, 0, 1, 0,   0,  1, 1, 0, 1, 0);
    va[5]  = mk(0,  1, 0, 0, 0,   1,  1, 0, 0, 1, 0);
    va[6]  = mk(3,  1, 0, 0, 0,   6,  1, 0, 0, 1, 1);
    va[7]  = mk(3,  1, 0, 0, 0,   11, 1, 0, 0, 1, 1);
    va[8]  = mk(3,  1, 0, 0, 0,   16, 1, 0, 0, 1, 1);
    va[9]  = mk(19, 0, 0, 0, 0,   16, 0, 0, 0, 1, 0);
    va[10] = mk(0,  1, 0, 0, 0,   17, 1, 0, 0, 1, 0);
    va[11] = mk(0,  0, 0, 1, 97,  97, 1, 0, 0, 1, 0);
    va[12] = mk(0,  1, 0, 0, 0,   98, 1, 0, 0, 1, 0);
    va[13] = mk(1,  1, 0, 0, 0,   3,  1, 0, 0, 1, 1);
    va[14] = mk(0,  0, 0, 1, 0,   0,  1, 1, 0, 1, 0);
    va[15] = mk(39, 0, 1, 0, 0,   99, 1, 0, 1, 0, 0);
    va[16] = mk(0,  0, 0, 1, 42,  42, 1, 0, 0, 0, 0);
    va[17] = mk(0,  1, 0, 0, 0,   43, 1, 0, 0, 1, 0);
    va[18] = mk(1,  1, 0, 0, 0,   48, 1, 0, 0, 1, 1);
    va[19] = mk(1,  1, 1, 0, 0,   48, 0, 0, 0, 1, 1);
    va[20] = mk(0,  1, 0, 0, 0,   53, 1, 0, 0, 1, 1);
    va[21] = mk(0,  1, 0, 1, 42,  42, 1, 0, 0, 1, 0);
    va[22] = mk(0,  1, 0, 0, 0,   43, 1, 0, 0, 1, 0);
    va[23] = mk(1,  1, 0, 0, 0,   48, 1, 0, 0, 1, 1);
    va[24] = mk(2,  0, 1, 0, 0,   47, 1, 0, 0, 0, 0);
    va[25] = mk(1,  1, 0, 0, 0,   48, 1, 0, 0, 1, 0);
    va[26] = mk(1,  1, 0, 0, 0,   53, 1, 0, 0, 1, 1);
    va[27] = mk(0,  0, 0, 1, 99,  99, 1, 0, 1, 1, 0);
    va[28] = mk(0,  1, 0, 0, 0,   0,  1, 1, 0, 1, 0);
    va[29] = mk(0,  0, 0, 1, 0,   0,  0, 1, 0, 1, 0);
    va[30] = mk(0,  0, 0, 1, 200, 99, 1, 0, 1, 1, 0);
    va[31] = mk(0,  1, 0, 0, 0,   0,  1, 1, 0, 1, 0);
    va[32] = mk(0,  1, 0, 0, 0,   5,  1, 0, 0, 1, 1);

    vb[0]  = mk(0,  0, 0, 1, 150, 99, 1, 0, 1, 1, 0);
    vb[1]  = mk(0,  1, 0, 0, 0,   99, 0, 0, 1, 1, 0);
    vb[2]  = mk(1,  1, 0, 0, 0,   99, 0, 0, 1, 1, 1);
    vb[3]  = mk(0,  0, 1, 0, 0,   98, 1, 0, 0, 0, 0);
    vb[4]  = mk(0,  0, 1, 0, 0,   93, 1, 0, 0, 0, 1);
    vb[5]  = mk(0,  0, 0, 1, 2,   2,  1, 0, 0, 0, 0);
    vb[6]  = mk(0,  0, 1, 0, 0,   1,  1, 0, 0, 0, 0);
    vb[7]  = mk(0,  0, 1, 0, 0,   0,  1, 1, 0, 0, 1);
    vb[8]  = mk(0,  0, 1, 0, 0,   0,  0, 1, 0, 0, 1);
    vb[9]  = mk(0,  1, 0, 0, 0,   1,  1, 0, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all("rst_wrap", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    sel_sat = 1'b1;
    chk_all("rst_sat", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    sel_sat = 1'b0;

    for (int i = 0; i < 33; i++) begin
      run_vec(va[i], $sformatf("wrap%0d", i));
    end

    // Reset while a fast burst is in progress; the next pulse must step by 1.
    do_reset(1'b1);
    chk_all("midburst_rst", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_vec(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0), "post_rst");

    do_reset(1'b0);
    sel_sat = 1'b1;
    chk_all("sat_rst", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run_vec(vb[i], $sformatf("sat%0d", i));
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
